// File: rtl/nios2_oci_dct_pkg.sv
// Shared widths and state encoding for the OCI compressed-trace (DCT) packer.
package nios2_oci_dct_pkg;
    localparam int ATOM_W         = 2;
    localparam int ATOMS_PER_WORD = 15;
    localparam int BUF_W          = ATOM_W * ATOMS_PER_WORD;
    localparam int DCT_CNT_W      = 4;
    localparam int OVF_CNT_W      = 8;

    localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(ATOMS_PER_WORD);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, ENDED} dct_state_t;
endpackage

// File: rtl/nios2_oci_dct_packer_if.sv
// Trace-atom input and DCT word valid/ready output of the packer.
interface nios2_oci_dct_packer_if;
    import nios2_oci_dct_pkg::*;

    logic                 atom_valid;
    logic [ATOM_W-1:0]    atom;
    logic                 end_req;
    logic                 word_valid;
    logic                 word_ready;
    logic [BUF_W-1:0]     dct_buffer;
    logic [DCT_CNT_W-1:0] dct_count;

    modport master (
        input  atom_valid, atom, end_req, word_ready,
        output word_valid, dct_buffer, dct_count
    );

    modport slave (
        output atom_valid, atom, end_req, word_ready,
        input  word_valid, dct_buffer, dct_count
    );
endinterface

// File: rtl/nios2_oci_dct_out_reg.sv
// Single-entry valid/ready holding register for one packed DCT word.
module nios2_oci_dct_out_reg
    import nios2_oci_dct_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic [BUF_W-1:0]     i_buf,
    input  logic [DCT_CNT_W-1:0] i_cnt,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [BUF_W-1:0]     o_buf,
    output logic [DCT_CNT_W-1:0] o_cnt,
    output logic                 o_empty,
    output logic                 o_accept
);
    logic                 r_valid;
    logic [BUF_W-1:0]     r_buf;
    logic [DCT_CNT_W-1:0] r_cnt;

    // A load in the accepting cycle keeps valid high: back-to-back words.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_buf   <= i_buf;
            r_cnt   <= i_cnt;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_buf    = r_buf;
    assign o_cnt    = r_cnt;
    assign o_empty  = !r_valid;
    assign o_accept = r_valid && i_ready;
endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT words; never stalls the CPU.
// Optional drop counter enabled by defining DCT_PACKER_OVF_EN.
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    nios2_oci_dct_packer_if.master bus,
    output logic [DCT_CNT_W-1:0]  o_fill_count,
    output logic                  o_test_ending,
    output logic                  o_test_has_ended,
    output logic [OVF_CNT_W-1:0]  o_ovf_count,
    output logic                  o_ovf_sticky
);
    dct_state_t           r_state, w_state_nxt;
    logic [BUF_W-1:0]     r_acc;
    logic [DCT_CNT_W-1:0] r_fill;
    logic                 w_full, w_empty, w_accept, w_free;
    logic                 w_load, w_acc_clr, w_atom_wr;

    assign w_full = (r_fill == FULL_CNT);
    assign w_free = w_empty || w_accept;

    nios2_oci_dct_out_reg u_out (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (w_load),
        .i_buf    (r_acc),
        .i_cnt    (r_fill),
        .i_ready  (bus.word_ready),
        .o_valid  (bus.word_valid),
        .o_buf    (bus.dct_buffer),
        .o_cnt    (bus.dct_count),
        .o_empty  (w_empty),
        .o_accept (w_accept)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= RUN;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_acc_clr   = 1'b0;
        w_atom_wr   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_full && w_free) begin
                    w_load    = 1'b1;
                    w_acc_clr = 1'b1;
                end
                // On a move the atom lands in slot 0 of the fresh accumulator.
                if (bus.atom_valid && (!w_full || w_free)) w_atom_wr = 1'b1;
                if (bus.end_req) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                if (r_fill == '0) begin
                    w_state_nxt = DRAIN;
                end else if (w_free) begin
                    w_load      = 1'b1;
                    w_acc_clr   = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN:   if (w_empty) w_state_nxt = ENDED;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (w_acc_clr) begin
            r_acc  <= w_atom_wr ? BUF_W'(bus.atom) : '0;
            r_fill <= w_atom_wr ? DCT_CNT_W'(1) : '0;
        end else if (w_atom_wr) begin
            r_acc  <= r_acc | (BUF_W'(bus.atom) << {r_fill, 1'b0});
            r_fill <= r_fill + DCT_CNT_W'(1);
        end
    end

    assign o_fill_count     = r_fill;
    assign o_test_ending    = (r_state == FLUSH) || (r_state == DRAIN);
    assign o_test_has_ended = (r_state == ENDED);

`ifdef DCT_PACKER_OVF_EN
    logic                 w_drop;
    logic [OVF_CNT_W-1:0] r_ovf_count;
    logic                 r_ovf_sticky;

    assign w_drop = (r_state == RUN) && bus.atom_valid && w_full && !w_free;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ovf_count  <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (w_drop) begin
            if (r_ovf_count != '1) r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
            r_ovf_sticky <= 1'b1;
        end
    end

    assign o_ovf_count  = r_ovf_count;
    assign o_ovf_sticky = r_ovf_sticky;
`else
    assign o_ovf_count  = '0;
    assign o_ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: queue-based reference model, negedge monitor.
module tb_nios2_oci_dct_packer;
    import nios2_oci_dct_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nios2_oci_dct_packer_if bus();
    logic [3:0] fill;
    logic       ending, ended;
    logic [7:0] ovf;
    logic       sticky;

    nios2_oci_dct_packer dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .bus              (bus),
        .o_fill_count     (fill),
        .o_test_ending    (ending),
        .o_test_has_ended (ended),
        .o_ovf_count      (ovf),
        .o_ovf_sticky     (sticky)
    );

    typedef struct packed {
        logic [29:0] data;
        logic [3:0]  cnt;
    } word_t;

    word_t      exp_q[$];
    logic [1:0] acc_q[$];
    bit         m_out_full;
    dct_state_t m_state;
    int         m_drops;
    bit         m_sticky;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic word_t pack_acc();
        word_t w;
        w = '0;
        for (int k = 0; k < acc_q.size(); k++) w.data[2*k +: 2] = acc_q[k];
        w.cnt = 4'(acc_q.size());
        return w;
    endfunction

    // Reference model: atoms queue up to 15 deep, one word slot downstream.
    task automatic model_step();
        bit free, load;
        if (rst) begin
            acc_q.delete(); exp_q.delete();
            m_out_full = 0; m_state = RUN; m_drops = 0; m_sticky = 0;
            return;
        end
        free = !m_out_full || bus.word_ready;
        load = 0;
        case (m_state)
            RUN: begin
                if (acc_q.size() == 15 && free) begin
                    exp_q.push_back(pack_acc()); acc_q.delete(); load = 1;
                end
                if (bus.atom_valid) begin
                    if (acc_q.size() < 15) acc_q.push_back(bus.atom);
                    else begin
                        if (m_drops < 255) m_drops++;
                        m_sticky = 1;
                    end
                end
                if (bus.end_req) m_state = FLUSH;
            end
            FLUSH: begin
                if (acc_q.size() == 0) m_state = DRAIN;
                else if (free) begin
                    exp_q.push_back(pack_acc()); acc_q.delete(); load = 1; m_state = DRAIN;
                end
            end
            DRAIN: if (!m_out_full) m_state = ENDED;
            default: ;
        endcase
        if (load) m_out_full = 1;
        else if (bus.word_ready) m_out_full = 0;
    endtask

    task automatic cyc(input bit av, input logic [1:0] a, input bit er, input bit rdy, input bit r = 0);
        bus.atom_valid = av; bus.atom = a; bus.end_req = er; bus.word_ready = rdy; rst = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: per-cycle status checks, stability while stalled, scoreboard pops.
    bit    hold = 0;
    word_t held;
    always @(negedge clk) begin
        word_t got, want;
        got = {bus.dct_buffer, bus.dct_count};
        check("word_valid", 32'(bus.word_valid), 32'(m_out_full));
        check("fill_count", 32'(fill), 32'(acc_q.size()));
        check("test_ending", 32'(ending), 32'(m_state == FLUSH || m_state == DRAIN));
        check("test_has_ended", 32'(ended), 32'(m_state == ENDED));
`ifdef DCT_PACKER_OVF_EN
        check("ovf_count", 32'(ovf), 32'(m_drops));
        check("ovf_sticky", 32'(sticky), 32'(m_sticky));
`else
        check("ovf_count", 32'(ovf), 32'd0);
        check("ovf_sticky", 32'(sticky), 32'd0);
`endif
        if (hold) begin
            check("hold_valid", 32'(bus.word_valid), 32'd1);
            check("hold_data", 32'(got), 32'(held));
        end
        hold = bus.word_valid && !bus.word_ready && !rst;
        held = got;
        if (bus.word_valid && bus.word_ready && !rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(got), 32'd0);
            end else begin
                want = exp_q.pop_front();
                check("dct_buffer", 32'(got.data), 32'(want.data));
                check("dct_count", 32'(got.cnt), 32'(want.cnt));
            end
        end
    end

    initial begin
        bus.atom_valid = 0; bus.atom = 0; bus.end_req = 0; bus.word_ready = 0; rst = 1;
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        check("reset_outputs", {bus.word_valid, fill, ending, ended, ovf, sticky}, 32'd0);

        // 15 mixed atoms, sink always ready
        for (int i = 0; i < 15; i++) cyc(1, 2'(i % 4), 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        drained("t1_drained");

        // 30 atoms of 3: two full words, no drops
        for (int i = 0; i < 30; i++) cyc(1, 2'b11, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        drained("t2_drained");

        // stalled sink: 31 atoms, one drop
        for (int i = 0; i < 31; i++) cyc(1, 2'($urandom_range(3)), 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        drained("t3_drained");

        // partial flush of four 2'b10 atoms, then end
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, 2'b10, 0, 1);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 2'b01, 1, 1);
        drained("t4_drained");
        check("t4_ended", 32'(ended), 32'd1);

        // end with everything empty; later atoms ignored
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 6; i++) cyc(1, 2'b11, 0, 1);
        drained("t5_drained");

        // reset while a word is pending
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) cyc(1, 2'($urandom_range(3)), 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        check("t6_pending", 32'(bus.word_valid), 32'd1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        // randomized segments
        for (int s = 0; s < 8; s++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(20, 100);
            cyc(0, 0, 0, 1, 1);
            for (int i = 0; i < 250; i++)
                cyc($urandom_range(99) < 75, 2'($urandom_range(3)),
                    $urandom_range(299) == 0, $urandom_range(99) < rdy_pct);
            for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1);
            drained("rand_drained");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
